i2c_xfer_engine: RTL and testbench
==================================

// Module: i2c_xfer_engine
// PURPOSE
//  I2C master transaction engine driven by the MMIO register block. It consumes slave_addr/reg_addr/write_data/rw/start
//  and runs one complete single-byte register access on the bus: a register write or a register read with repeated START.
//  It returns read_data plus sticky done/ack_error status to the MMIO readback, and drives open-drain SDA/SCL enables to the pad.
// PARAMETERS
//  CLK_DIV   125   clk cycles per quarter SCL period; SCL period = 4*CLK_DIV (50 MHz -> 100 kHz); legal >= 2
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-high
//  start       in   1  level from MMIO; transfer launched on 0->1 edge only
//  slave_addr  in   7  7-bit target address
//  reg_addr    in   8  target register index
//  write_data  in   8  byte written when rw=0
//  rw          in   1  0 = register write, 1 = register read
//  read_data   out  8  byte captured in read phase
//  done        out  1  sticky: transfer finished (ok or error)
//  ack_error   out  1  sticky: slave NACKed an address/data byte
//  busy        out  1  transaction in progress
//  sda_oe      out  1  1 = pull SDA low (open drain), 0 = release
//  sda_in      in   1  SDA pad value (synchronised inside, 2 flops)
//  scl_oe      out  1  1 = pull SCL low, 0 = release
// BEHAVIOUR
//  Reset: state IDLE, read_data=0, done=0, ack_error=0, busy=0, sda_oe=0, scl_oe=0, divider=0, start edge reg=0.
//  Quarter tick: divider counts 0..CLK_DIV-1, qtick at CLK_DIV-1; runs only when busy, cleared in IDLE.
//  Launch: start rising edge in IDLE -> inputs latched into shadow regs, done<=0, ack_error<=0, busy<=1 next cycle.
//   start edge while busy ignored (not queued). Inputs changing mid-transfer have no effect.
//  Bit phase (4 qticks): q0 SCL low, SDA changes; q1 SCL low; q2 SCL released; q3 SCL high, sample sda_in at end.
//  States: IDLE -> START -> ADDR_W(8) -> ACK1 -> REG(8) -> ACK2 -> {rw=0: WDATA(8) -> ACK3 -> STOP}
//          {rw=1: RSTART -> ADDR_R(8) -> ACK4 -> RDATA(8) -> MNACK -> STOP} ; STOP -> IDLE.
//  START/RSTART: SDA high with SCL high, then SDA low while SCL high, then SCL low. STOP: SDA low, SCL high, SDA released.
//  Bytes MSB first; address byte = {slave_addr, 0} for write, {slave_addr, 1} for read.
//  ACK phases: SDA released; sampled 1 = NACK -> ack_error<=1, jump to STOP (remaining bytes skipped).
//  RDATA: SDA released, shift sampled bits MSB first; read_data updated only on completion of the 8th bit.
//  MNACK: master releases SDA (NACK) for the single read byte.
//  STOP end: busy<=0, done<=1 same clk; sda_oe=scl_oe=0 in IDLE. done/ack_error hold until next launch or reset.
//  Total write = 1+27+1 bit-times; read = 1+18+1+18+1 bit-times (START/STOP count one bit-time each).
//  Reset mid-transfer: immediate release of both lines, all state to reset values, no STOP generated.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined: scl_in port (1 bit) added; in q3 the divider holds while scl_in=0 (slave stretch),
//   resuming when scl_in reads 1 after 2-flop sync. Not defined: no scl_in port, SCL timing purely from divider.
// STRUCTURE
//  i2c_pkg: state encoding localparams, address R/W bit constants, QPHASE_* indices.
//  Sub-module i2c_qtick_gen: divider + qtick + quarter index (and stretch hold when macro set); engine is the FSM + shifters.
// TESTING
//  Write: slave 0x50 ACKs all, reg 0x10, data 0xA5, CLK_DIV=4 -> bus bytes A0,10,A5, STOP; done=1, ack_error=0, busy low.
//  Read: slave model returns 0x3C at reg 0x22 -> bytes A0,22, Sr, A1, master NACK; read_data=0x3C, done=1.
//  Address NACK: no slave at 0x51 -> STOP right after ACK1, ack_error=1, done=1, no reg byte on bus.
//  start held high after done -> no second transfer; toggle 0->1 -> new transfer, done cleared at launch.
//  Reset asserted mid REG byte -> sda_oe=scl_oe=0, busy=0, done=0 within same cycle; next start works normally.
//  I2C_CLK_STRETCH_EN: slave holds SCL low 50 clks in ACK2 -> bit timing extended by 50, data still correct.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C master transaction engine: FSM states,
// R/W bit values and quarter-phase indices of one SCL bit-time.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_ADDR_W = 4'd2,
    S_ACK1   = 4'd3,
    S_REG    = 4'd4,
    S_ACK2   = 4'd5,
    S_WDATA  = 4'd6,
    S_ACK3   = 4'd7,
    S_RSTART = 4'd8,
    S_ADDR_R = 4'd9,
    S_ACK4   = 4'd10,
    S_RDATA  = 4'd11,
    S_MNACK  = 4'd12,
    S_STOP   = 4'd13
  } state_t;

  localparam logic ADDR_WRITE = 1'b0;
  localparam logic ADDR_READ  = 1'b1;

  localparam logic [1:0] QPHASE_0 = 2'd0;
  localparam logic [1:0] QPHASE_1 = 2'd1;
  localparam logic [1:0] QPHASE_2 = 2'd2;
  localparam logic [1:0] QPHASE_3 = 2'd3;

  function automatic logic is_byte_state(input state_t s);
    return s inside {S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA};
  endfunction

  function automatic logic is_ack_state(input state_t s);
    return s inside {S_ACK1, S_ACK2, S_ACK3, S_ACK4};
  endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit timebase: divider, qtick strobe and quarter index.
// With I2C_CLK_STRETCH_EN defined, q3 holds while a slave stretches SCL.
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       scl_in,
`endif
  output logic       qtick,
  output logic [1:0] qphase
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div;
  logic          hold;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_meta, scl_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
    end
  end

  // SCL was released at q2; a low reading in q3 means a slave is stretching.
  assign hold = (qphase == QPHASE_3) && !scl_sync;
`else
  assign hold = 1'b0;
`endif

  assign qtick = run && !hold && (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      qphase <= QPHASE_0;
    end else if (!run) begin
      div    <= '0;
      qphase <= QPHASE_0;
    end else if (!hold) begin
      div <= qtick ? '0 : div + 1'b1;
      if (qtick) qphase <= qphase + 2'd1;
    end
  end

endmodule

// File: rtl/i2c_xfer_engine.sv
// I2C master engine: one single-byte register write, or register read with
// repeated START, per start edge. Optional slave clock stretch: I2C_CLK_STRETCH_EN.
module i2c_xfer_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] write_data,
  input  logic       rw,
  output logic [7:0] read_data,
  output logic       done,
  output logic       ack_error,
  output logic       busy,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       scl_oe
`ifdef I2C_CLK_STRETCH_EN
  ,
  input  logic       scl_in
`endif
);

  state_t     state, state_nxt;
  logic       start_q, start_rise;
  logic       sda_meta, sda_sync;
  logic [6:0] slave_q;
  logic [7:0] reg_q, wdata_q;
  logic       rw_q;
  logic [7:0] tx_sr, rx_sr;
  logic [2:0] bit_cnt;
  logic       qtick, bit_end, byte_last;
  logic [1:0] qphase;
  logic       sda_low, scl_low;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .reset (reset),
    .run   (busy),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in(scl_in),
`endif
    .qtick (qtick),
    .qphase(qphase)
  );

  assign start_rise = start && !start_q;
  assign bit_end    = qtick && (qphase == QPHASE_3);
  assign byte_last  = bit_end && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_rise) state_nxt = S_START;
      S_START:  if (bit_end)    state_nxt = S_ADDR_W;
      S_ADDR_W: if (byte_last)  state_nxt = S_ACK1;
      S_ACK1:   if (bit_end)    state_nxt = sda_sync ? S_STOP : S_REG;
      S_REG:    if (byte_last)  state_nxt = S_ACK2;
      S_ACK2:   if (bit_end)    state_nxt = sda_sync ? S_STOP : (rw_q ? S_RSTART : S_WDATA);
      S_WDATA:  if (byte_last)  state_nxt = S_ACK3;
      S_ACK3:   if (bit_end)    state_nxt = S_STOP;
      S_RSTART: if (bit_end)    state_nxt = S_ADDR_R;
      S_ADDR_R: if (byte_last)  state_nxt = S_ACK4;
      S_ACK4:   if (bit_end)    state_nxt = sda_sync ? S_STOP : S_RDATA;
      S_RDATA:  if (byte_last)  state_nxt = S_MNACK;
      S_MNACK:  if (bit_end)    state_nxt = S_STOP;
      S_STOP:   if (bit_end)    state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Bus drive per quarter; lines are registered below so the pads never glitch.
  always_comb begin
    sda_low = 1'b0;
    scl_low = 1'b0;
    case (state)
      S_IDLE:   ;
      S_START:  sda_low = qphase[1];
      S_RSTART: begin
        scl_low = (qphase == QPHASE_0);
        sda_low = qphase[1];
      end
      S_STOP: begin
        scl_low = !qphase[1];
        sda_low = (qphase != QPHASE_3);
      end
      S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
        scl_low = !qphase[1];
        sda_low = !tx_sr[7];
      end
      default:  scl_low = !qphase[1];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      slave_q   <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      read_data <= '0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      busy      <= 1'b0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
    end else begin
      start_q  <= start;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
      sda_oe   <= sda_low;
      scl_oe   <= scl_low;

      if (state == S_IDLE && start_rise) begin
        slave_q   <= slave_addr;
        reg_q     <= reg_addr;
        wdata_q   <= write_data;
        rw_q      <= rw;
        done      <= 1'b0;
        ack_error <= 1'b0;
        busy      <= 1'b1;
      end

      if (bit_end) begin
        if (is_byte_state(state)) begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sr   <= {tx_sr[6:0], 1'b0};
          rx_sr   <= {rx_sr[6:0], sda_sync};
        end
        if (is_ack_state(state) && sda_sync) ack_error <= 1'b1;
        if (state == S_RDATA && bit_cnt == 3'd7) read_data <= {rx_sr[6:0], sda_sync};
        if (state == S_STOP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        if (state_nxt != state) begin
          bit_cnt <= '0;
          case (state_nxt)
            S_ADDR_W: tx_sr <= {slave_q, ADDR_WRITE};
            S_REG:    tx_sr <= reg_q;
            S_WDATA:  tx_sr <= wdata_q;
            S_ADDR_R: tx_sr <= {slave_q, ADDR_READ};
            default:  ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_xfer_engine.sv
// Directed bench for i2c_xfer_engine with a behavioural I2C slave at 0x50.
// Build with I2C_CLK_STRETCH_EN to also exercise slave clock stretching.
module tb_i2c_xfer_engine;

  localparam int CLK_DIV = 4;
  localparam int BIT_CYC = 4 * CLK_DIV;
  localparam int EV_S    = 'h100;
  localparam int EV_P    = 'h101;
  localparam logic [6:0] SLV = 7'h50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] write_data = '0;
  logic       rw = 1'b0;
  logic [7:0] read_data;
  logic       done, ack_error, busy, sda_oe, scl_oe;
  logic       sda_bus, scl_bus;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state
  logic       slave_low = 1'b0;
  logic       slave_scl_low = 1'b0;
  logic       stretch_en = 1'b0;
  logic       scl_p, sda_p, addressed, reading, last_ack;
  logic [7:0] shreg, tx, reg_ptr;
  logic [7:0] mem [256];
  int         bitn, byte_idx, stretch_cnt;
  int         ev_log[$];
  int         exp_q[$];
  int         log_base;

  assign scl_bus = !(scl_oe || slave_scl_low);
  assign sda_bus = !(sda_oe || slave_low);

  always #5 clk = ~clk;

  i2c_xfer_engine #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .slave_addr(slave_addr),
    .reg_addr  (reg_addr),
    .write_data(write_data),
    .rw        (rw),
    .read_data (read_data),
    .done      (done),
    .ack_error (ack_error),
    .busy      (busy),
    .sda_oe    (sda_oe),
    .sda_in    (sda_bus),
    .scl_oe    (scl_oe)
`ifdef I2C_CLK_STRETCH_EN
    ,
    .scl_in    (scl_bus)
`endif
  );

  // Behavioural slave: logs START/STOP/bytes seen on the bus, ACKs SLV,
  // stores written bytes and returns mem[reg_ptr] on a read.
  always @(negedge clk) begin
    if (reset) begin
      slave_low = 1'b0; slave_scl_low = 1'b0; stretch_cnt = 0;
      bitn = 0; byte_idx = 0; addressed = 1'b0; reading = 1'b0;
      scl_p = 1'b1; sda_p = 1'b1; last_ack = 1'b0;
      mem[8'h22] = 8'h3C;
    end else begin
      if (stretch_cnt > 0) begin
        stretch_cnt--;
        if (stretch_cnt == 0) slave_scl_low = 1'b0;
      end
      if (scl_bus && scl_p && sda_p && !sda_bus) begin
        ev_log.push_back(EV_S);
        bitn = 0; byte_idx = 0; slave_low = 1'b0; addressed = 1'b0; reading = 1'b0;
      end else if (scl_bus && scl_p && !sda_p && sda_bus) begin
        ev_log.push_back(EV_P);
        bitn = 0; byte_idx = 0; slave_low = 1'b0; addressed = 1'b0; reading = 1'b0;
      end else if (scl_bus && !scl_p) begin
        if (bitn < 8) shreg = {shreg[6:0], sda_bus};
        else          last_ack = sda_bus;
        if (bitn < 9) bitn++;
        if (bitn == 8) ev_log.push_back(int'(shreg));
      end else if (!scl_bus && scl_p) begin
        if (bitn == 8) begin
          if (byte_idx == 0) begin
            addressed = (shreg[7:1] == SLV);
            reading   = shreg[0];
          end else if (addressed && !reading) begin
            if (byte_idx == 1) reg_ptr = shreg;
            else               mem[reg_ptr] = shreg;
          end
          slave_low = addressed && (byte_idx == 0 || !reading);
          if (stretch_en && addressed && !reading && byte_idx == 1) begin
            slave_scl_low = 1'b1;
            stretch_cnt   = 50;
          end
          byte_idx++;
        end else if (bitn == 9) begin
          bitn = 0;
          slave_low = 1'b0;
          if (addressed && reading && !last_ack) begin
            tx = mem[reg_ptr];
            slave_low = !tx[7];
          end
        end else if (addressed && reading && byte_idx >= 1 && bitn > 0) begin
          slave_low = !tx[3'(7 - bitn)];
        end
      end
      scl_p = scl_bus;
      sda_p = sda_bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic check_bus(input string tag);
    check({tag, "_nev"}, ev_log.size() - log_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && log_base + i < ev_log.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), ev_log[log_base + i], exp_q[i]);
  endtask

  // Launch one transfer; mid-flight it scrambles the inputs and re-pulses
  // start, neither of which may affect the running transfer.
  task automatic run_xfer(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d,
                          input logic rw_i, output int cycles);
    start = 1'b0;
    @(negedge clk);
    log_base   = ev_log.size();
    slave_addr = a; reg_addr = r; write_data = d; rw = rw_i; start = 1'b1;
    @(negedge clk);
    check("launch_busy", 32'(busy), 1);
    check("launch_done_clr", 32'(done), 0);
    cycles = 0;
    while (busy && cycles < 3000) begin
      cycles++;
      if (cycles == 3) begin
        start = 1'b0; slave_addr = ~a; reg_addr = ~r; write_data = ~d; rw = ~rw_i;
      end
      if (cycles == 6) start = 1'b1;
      @(negedge clk);
    end
    check("end_busy", 32'(busy), 0);
  endtask

  initial begin
    int   cyc;
    logic seen;

    repeat (3) @(negedge clk);
    check("rst_read_data", 32'(read_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ack_error", 32'(ack_error), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_scl_oe", 32'(scl_oe), 0);
    reset = 1'b0;
    @(negedge clk);

    // Register write, all bytes ACKed
    run_xfer(7'h50, 8'h10, 8'hA5, 1'b0, cyc);
    check("wr_cycles", cyc, 29 * BIT_CYC);
    check("wr_done", 32'(done), 1);
    check("wr_ack_error", 32'(ack_error), 0);
    check("wr_read_data", 32'(read_data), 0);
    exp_q = {EV_S, 'hA0, 'h10, 'hA5, EV_P};
    check_bus("wr");
    check("wr_mem", 32'(mem[8'h10]), 'hA5);

    // start still high after done: no relaunch
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("hold_no_relaunch", 32'(seen), 0);
    check("hold_done", 32'(done), 1);

    // Register read with repeated START
`ifdef I2C_CLK_STRETCH_EN
    stretch_en = 1'b1;
`endif
    run_xfer(7'h50, 8'h22, 8'h00, 1'b1, cyc);
`ifdef I2C_CLK_STRETCH_EN
    check("rd_stretch_len", 32'(cyc > 39 * BIT_CYC + 30 && cyc < 39 * BIT_CYC + 60), 1);
    stretch_en = 1'b0;
`else
    check("rd_cycles", cyc, 39 * BIT_CYC);
`endif
    check("rd_read_data", 32'(read_data), 'h3C);
    check("rd_done", 32'(done), 1);
    check("rd_ack_error", 32'(ack_error), 0);
    exp_q = {EV_S, 'hA0, 'h22, EV_S, 'hA1, 'h3C, EV_P};
    check_bus("rd");
    check("rd_master_nack", 32'(last_ack), 1);

    // Address NACK: nobody at 0x51
    run_xfer(7'h51, 8'h10, 8'h77, 1'b0, cyc);
    check("nack_cycles", cyc, 11 * BIT_CYC);
    check("nack_ack_error", 32'(ack_error), 1);
    check("nack_done", 32'(done), 1);
    exp_q = {EV_S, 'hA2, EV_P};
    check_bus("nack");

    // Reset while the REG byte drives a 0 with SCL low
    start = 1'b0;
    @(negedge clk);
    slave_addr = 7'h50; reg_addr = 8'h10; write_data = 8'h5A; rw = 1'b0; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk);
      if (byte_idx == 1 && bitn == 4 && !scl_bus) seen = 1'b1;
    end
    check("rst_mid_reach_reg", 32'(seen), 1);
    #2 reset = 1'b1;
    start = 1'b0;
    #1;
    check("rst_mid_sda_oe", 32'(sda_oe), 0);
    check("rst_mid_scl_oe", 32'(scl_oe), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_xfer(7'h50, 8'h10, 8'h5A, 1'b0, cyc);
    check("post_rst_cycles", cyc, 29 * BIT_CYC);
    check("post_rst_done", 32'(done), 1);
    check("post_rst_ack_error", 32'(ack_error), 0);
    exp_q = {EV_S, 'hA0, 'h10, 'h5A, EV_P};
    check_bus("post_rst");
    check("post_rst_mem", 32'(mem[8'h10]), 'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
